// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default iteration count.
package div_seq_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  assign trial   = {rem_in, dvd_bit};
  assign q_bit   = (trial >= {1'b0, divisor});
  // The partial remainder stays below the divisor, so the difference always fits in WIDTH bits.
  assign rem_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU producing {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes in one cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_div
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    neg_if = n ? (~v + 1'b1) : v;
  endfunction

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             ready_r;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fin_quot;
  logic             dvz;

  assign a_neg    = signed_div & opdata1[WIDTH-1];
  assign b_neg    = signed_div & opdata2[WIDTH-1];
  assign accept   = (state == DIV_IDLE) && start && !annul;
  assign fin_quot = {dvd[WIDTH-2:0], step_q};
  assign dvz      = (dvs == '0);

  assign stall_div = accept || (state == DIV_RUN);
  assign ready     = ready_r & ~annul;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Control: FSM, iteration counter, registered result and ready pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      result  <= '0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (FAST_DZ && (opdata2 == '0)) begin
              result  <= {opdata1, {WIDTH{1'b1}}};
              ready_r <= 1'b1;
              state   <= DIV_DONE;
            end else begin
              state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (annul) begin
            state <= DIV_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state   <= DIV_DONE;
              ready_r <= 1'b1;
              if (dvz) result <= {dvd_raw, {WIDTH{1'b1}}};
              else     result <= {neg_if(step_rem, r_neg), neg_if(fin_quot, q_neg)};
            end
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  // Datapath: operand magnitudes latched once at start, then shifted per step
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= '0;
      dvd     <= neg_if(opdata1, a_neg);
      dvs     <= neg_if(opdata2, b_neg);
      dvd_raw <= opdata1;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
    end else if (state == DIV_RUN) begin
      rem <= step_rem;
      dvd <= fin_quot;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model, per-cycle compare, directed vectors.
module tb_div_seq;

  localparam int W = 32;
  localparam int LAT = 33;
`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          signed_div = 1'b0;
  logic          annul = 1'b0;
  logic [W-1:0]  opdata1 = '0;
  logic [W-1:0]  opdata2 = '0;
  logic [2*W-1:0] result;
  logic          ready;
  logic          stall_div;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  bit check_on = 1'b0;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_div  (stall_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: {remainder, quotient} straight from the division rules
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sd) return {a % b, a / b};
    sa = a;
    sb = b;
    if (sa == 32'sh8000_0000 && sb == -1) return {32'd0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Model of the operation in flight
  bit          m_busy = 1'b0;
  int          m_done_at = 0;
  logic [63:0] m_exp = '0;
  logic [63:0] m_last = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_last <= '0;
    end else begin
      if (m_busy && cyc == m_done_at) begin
        m_busy <= 1'b0;
        m_last <= m_exp;
      end else if (m_busy && annul) begin
        m_busy <= 1'b0;
      end else if (!m_busy && start && !annul) begin
        m_busy    <= 1'b1;
        m_done_at <= cyc + ((opdata2 == 32'd0) ? DZ_LAT : LAT);
        m_exp     <= ref_div(signed_div, opdata1, opdata2);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (check_on) begin
      logic done_now;
      done_now = m_busy && (cyc == m_done_at);
      chk("stall_div", 64'(stall_div), 64'((!m_busy && start && !annul) || (m_busy && cyc < m_done_at)));
      chk("ready", 64'(ready), 64'(done_now && !annul));
      chk("result", result, done_now ? m_exp : m_last);
    end
  end

  task automatic start_op(input logic sd, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    signed_div = sd;
    opdata1 = a;
    opdata2 = b;
    t0 = cyc;
    @(posedge clk);
    #1;
    // Later operand changes must not affect the running operation
    opdata1 = ~a;
    opdata2 = a ^ b ^ 32'h5A5A_0001;
  endtask

  task automatic wait_done(input string name, input logic [63:0] lit, input int lat);
    int n;
    n = 0;
    while (!ready && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({name, "_timeout"}, 64'(0), 64'(1));
    else begin
      chk({name, "_lat"}, 64'(cyc - t0), 64'(lat));
      chk({name, "_val"}, result, lit);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_div(input string name, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] lit, input int lat);
    @(posedge clk);
    #1;
    start_op(sd, a, b);
    wait_done(name, lit, lat);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stall_div), 64'd0);
    resetn = 1'b1;
    check_on = 1'b1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, LAT);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, LAT);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, LAT);
    do_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, LAT);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DZ_LAT);
    do_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, {32'hFFFF_FFF7, 32'hFFFF_FFFF}, DZ_LAT);
    do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, LAT);
    do_div("divu_0_3", 1'b0, 32'd0, 32'd3, {32'd0, 32'd0}, LAT);

    // Abort at T+10, restart at T+11, completion expected at T+44
    @(posedge clk);
    #1;
    start_op(1'b0, 32'd1000, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("annul_at_t10", 64'(cyc - t0), 64'd10);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    chk("annul_result_kept", result, {32'd0, 32'd0});
    begin
      int ta;
      ta = t0;
      start_op(1'b0, 32'd1000, 32'd7);
      t0 = ta;
    end
    wait_done("after_annul", {32'd6, 32'd142}, 44);

    // Reset in the middle of RUN
    @(posedge clk);
    #1;
    start_op(1'b0, 32'd1000, 32'd3);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rst_at_t5", 64'(cyc - t0), 64'd5);
    resetn = 1'b0;
    #1;
    chk("midrst_result", result, 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_stall", 64'(stall_div), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, LAT);

    repeat (3) @(posedge clk);
    check_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
